escalonador_botoes: RTL and testbench

Button-panel event scheduler for the Tamagotchi game core. It takes N raw active-low push-buttons and debounces each one. It classifies every press as short or long. Events from all buttons are arbitrated round-robin into a small FIFO, which the game FSM drains through a valid/ready handshake, so simultaneous presses are serialised and never lost while space remains.

---
 rtl/botao_pkg.sv | 29 ++
 rtl/filtro_botao.sv | 92 +++++++++
 rtl/escalonador_botoes.sv | 205 ++++++++++++++++++++
 tb/tb_escalonador_botoes.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/botao_pkg.sv
// Shared definitions for the button-panel event scheduler.
// Contents:
// - Id-width derivation helper.
// - Button id constants.
// - Event word layout: {id, long}, with long in bit 0.
// - Default debounce and long-press timing.
package botao_pkg;

  localparam int DEB_BITS_DEF = 4;
  localparam int LONG_CYC_DEF = 1000;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;

  // Event word layout: {id, long}. The long flag sits in bit 0.
  localparam int EVT_LONG_BIT = 0;

  // Button id width; a single button still needs one bit.
  function automatic int id_width(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Width of one queued event word.
  function automatic int evt_width(input int n_btn);
    return id_width(n_btn) + 1;
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// Front end for one raw active-low push-button.
// Contains a 2-flop synchroniser, the debounce filter, the hold counter and
// short/long press classification.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   b_raw      - raw button, 0 = pressed, asynchronous to clk
//   evt        - one-cycle pulse when a press event is produced
//   evt_long   - qualifies evt: 1 = long press, 0 = short press
module filtro_botao
  import botao_pkg::*;
#(
  parameter int DEB_BITS = DEB_BITS_DEF,
  parameter int LONG_CYC = LONG_CYC_DEF,
  localparam int HW = $clog2(LONG_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_raw,
  output logic evt,
  output logic evt_long
);

  localparam logic [DEB_BITS-1:0] DEB_MAX  = {DEB_BITS{1'b1}};
  localparam logic [DEB_BITS-1:0] DEB_ZERO = {DEB_BITS{1'b0}};
  localparam logic [DEB_BITS-1:0] DEB_ONE  = DEB_BITS'(1);
  localparam logic [HW-1:0]       HOLD_MAX = HW'(LONG_CYC);
  localparam logic [HW-1:0]       HOLD_PRE = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0]       HOLD_ONE = HW'(1);

  logic                sync1_r;
  logic                sync2_r;
  logic                deb_r;
  logic [DEB_BITS-1:0] deb_cnt_r;
  logic [HW-1:0]       hold_r;
  logic                evt_r;
  logic                evt_long_r;
  logic                flip_s;

  // The debounced level changes on this cycle's edge.
  assign flip_s = (sync2_r != deb_r) && (deb_cnt_r == DEB_MAX);

  // Synchroniser, debounce, hold counter and event pulse generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      deb_r      <= 1'b1;
      deb_cnt_r  <= DEB_ZERO;
      hold_r     <= {HW{1'b0}};
      evt_r      <= 1'b0;
      evt_long_r <= 1'b0;
    end else begin
      sync1_r <= b_raw;
      sync2_r <= sync1_r;

      if (sync2_r == deb_r) begin
        deb_cnt_r <= DEB_ZERO;
      end else if (flip_s) begin
        deb_r     <= sync2_r;
        deb_cnt_r <= DEB_ZERO;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_ONE;
      end

      // Hold counter restarts on press and saturates at LONG_CYC.
      if (flip_s && deb_r) begin
        hold_r <= {HW{1'b0}};
      end else if (!deb_r && !flip_s && (hold_r != HOLD_MAX)) begin
        hold_r <= hold_r + HOLD_ONE;
      end else begin
        hold_r <= hold_r;
      end

      // Release gives a short event unless a long one was already issued;
      // the long event fires on the edge where hold reaches LONG_CYC.
      if (flip_s && !deb_r) begin
        evt_r      <= (hold_r != HOLD_MAX);
        evt_long_r <= 1'b0;
      end else if (!deb_r && !flip_s && (hold_r == HOLD_PRE)) begin
        evt_r      <= 1'b1;
        evt_long_r <= 1'b1;
      end else begin
        evt_r      <= 1'b0;
        evt_long_r <= 1'b0;
      end
    end
  end

  assign evt      = evt_r;
  assign evt_long = evt_long_r;

endmodule

// File: rtl/escalonador_botoes.sv
// Button-panel event scheduler.
// Each button is filtered by filtro_botao. Its events are held in a
// per-button pending flag, arbitrated round-robin into a first-word-fall-
// through FIFO, and drained through a valid/ready handshake.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   b_in         - raw buttons, 0 = pressed
//   evt_ready    - consumer takes the head event
//   clr_ovf      - clears the sticky overflow flag
//   evt_valid    - FIFO non-empty
//   evt_id       - button id of the head event
//   evt_long     - long-press flag of the head event
//   overflow     - sticky, an event was dropped
// FIFO_DEPTH must be a power of 2 and at least 2.
module escalonador_botoes
  import botao_pkg::*;
#(
  parameter int N_BTN      = 3,
  parameter int DEB_BITS   = DEB_BITS_DEF,
  parameter int LONG_CYC   = 100,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] b_in,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_long,
  output logic             overflow
);

  localparam int EW = evt_width(N_BTN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = IDW + 1;
  localparam logic [PW:0] CNT_ZERO = {(PW + 1){1'b0}};
  localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  logic [N_BTN-1:0] evt_s;
  logic [N_BTN-1:0] evt_long_s;
  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] pend_long_r;
  logic [N_BTN-1:0] gnt_mask_s;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   gnt_id_s;
  logic             found_s;
  logic             drop_s;
  logic             overflow_r;

  logic [EW-1:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_n_s;
  logic [PW:0]      cnt_r;
  logic [PW:0]      cnt_n_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic [EW-1:0]    push_data_s;
  logic [EW-1:0]    head_n_s;
  logic [EW-1:0]    head_r;
  logic             evt_valid_r;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    filtro_botao #(
      .DEB_BITS (DEB_BITS),
      .LONG_CYC (LONG_CYC)
    ) u_filtro (
      .clk      (clk),
      .rst_n    (rst_n),
      .b_raw    (b_in[g]),
      .evt      (evt_s[g]),
      .evt_long (evt_long_s[g])
    );
  end

  // Round-robin search for the first pending button starting at rr_ptr_r.
  always_comb begin
    logic [SW-1:0] idx_v;
    idx_v    = {SW{1'b0}};
    found_s  = 1'b0;
    gnt_id_s = {IDW{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      idx_v = {1'b0, rr_ptr_r} + SW'(i);
      if (idx_v >= SW'(N_BTN)) begin
        idx_v = idx_v - SW'(N_BTN);
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && pending_r[idx_v[IDW-1:0]]) begin
        found_s  = 1'b1;
        gnt_id_s = idx_v[IDW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // FIFO next-state. Full is judged on registered state, so a same-cycle
  // pop never makes room for that cycle's push.
  always_comb begin
    full_s      = (cnt_r == CNT_FULL);
    pop_s       = (cnt_r != CNT_ZERO) && evt_ready;
    push_s      = found_s && !full_s;
    push_data_s = {gnt_id_s, pend_long_r[gnt_id_s]};
    if (pop_s) begin
      rd_n_s = rd_ptr_r + PW'(1);
    end else begin
      rd_n_s = rd_ptr_r;
    end
    if (push_s && !pop_s) begin
      cnt_n_s = cnt_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      cnt_n_s = cnt_r - CNT_ONE;
    end else begin
      cnt_n_s = cnt_r;
    end
    // The new head bypasses memory when it is the entry being pushed now.
    if (cnt_n_s == CNT_ZERO) begin
      head_n_s = {EW{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_n_s)) begin
      head_n_s = push_data_s;
    end else begin
      head_n_s = mem_r[rd_n_s];
    end
  end

  // One-hot of the button being pushed this cycle.
  always_comb begin
    gnt_mask_s = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      gnt_mask_s[i] = push_s && (gnt_id_s == IDW'(i));
    end
  end

  // A new event drops only if its flag stays set through this edge.
  assign drop_s = |(evt_s & pending_r & ~gnt_mask_s);

  // Pending flags, round-robin pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= {N_BTN{1'b0}};
      pend_long_r <= {N_BTN{1'b0}};
      rr_ptr_r    <= {IDW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (evt_s[i] && (!pending_r[i] || gnt_mask_s[i])) begin
          pending_r[i]   <= 1'b1;
          pend_long_r[i] <= evt_long_s[i];
        end else if (gnt_mask_s[i]) begin
          pending_r[i]   <= 1'b0;
        end else begin
          pending_r[i]   <= pending_r[i];
        end
      end
      if (push_s) begin
        rr_ptr_r <= (gnt_id_s == IDW'(N_BTN - 1)) ? {IDW{1'b0}} : (gnt_id_s + IDW'(1));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // FIFO storage, pointers and registered head/valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      cnt_r       <= CNT_ZERO;
      head_r      <= {EW{1'b0}};
      evt_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_n_s;
      cnt_r       <= cnt_n_s;
      head_r      <= head_n_s;
      evt_valid_r <= (cnt_n_s != CNT_ZERO);
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_id    = head_r[EW-1:1];
  assign evt_long  = head_r[EVT_LONG_BIT];
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_escalonador_botoes.sv
// Self-checking bench for escalonador_botoes (DEB_BITS=4, LONG_CYC=100).
// Inputs are driven and outputs sampled on the falling clock edge.
// Timing reference: a raw level driven at falling edge 0 and then held
// flips the debounced level at rising edge 18, and evt_valid is seen at
// falling edge 20.
module tb_escalonador_botoes;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] b_in;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_long;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  escalonador_botoes #(
    .N_BTN      (3),
    .DEB_BITS   (4),
    .LONG_CYC   (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_in      (b_in),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_long  (evt_long),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;
    int         low;      // cycles held low
    bit         exp_evt;
    bit         exp_long;
    int         exp_lat;  // falling edges from press start to evt_valid
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    b_in = 3'b111;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One button pressed for v.low cycles. Expect at most one event.
  task automatic run_vec(input vec_t v, input string name);
    int seen;
    int sid;
    int slong;
    seen = 0;
    sid = -1;
    slong = -1;
    evt_ready = 1'b0;
    @(negedge clk);
    b_in[v.btn] = 1'b0;
    for (int k = 1; k <= v.low + 45; k++) begin
      @(negedge clk);
      if (evt_valid && seen == 0) begin
        seen = k;
        sid = int'(evt_id);
        slong = int'(evt_long);
      end
      if (k == v.low) b_in[v.btn] = 1'b1;
    end
    if (v.exp_evt) begin
      check({name, "_lat"}, seen, v.exp_lat);
      check({name, "_id"}, sid, int'(v.btn));
      check({name, "_long"}, slong, int'(v.exp_long));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end else begin
      check({name, "_noevt"}, seen, 0);
    end
    check({name, "_single"}, int'(evt_valid), 0);
  endtask

  // Short press on a single button; waits long enough for the push.
  task automatic short_press(input int btn);
    @(negedge clk);
    b_in[btn] = 1'b0;
    repeat (20) @(negedge clk);
    b_in[btn] = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  // All three buttons pressed and released together, evt_ready held high.
  task automatic sim_press(input int e0, input int e1, input int e2, input string name);
    int got_n;
    int first_k;
    int last_k;
    int ids[4];
    got_n = 0;
    first_k = 0;
    last_k = 0;
    for (int i = 0; i < 4; i++) ids[i] = -1;
    evt_ready = 1'b1;
    @(negedge clk);
    b_in = 3'b000;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (evt_valid) begin
        if (got_n == 0) first_k = k;
        last_k = k;
        if (got_n < 4) ids[got_n] = int'(evt_id);
        got_n++;
      end
      if (k == 20) b_in = 3'b111;
    end
    evt_ready = 1'b0;
    check({name, "_first"}, first_k, 40);
    check({name, "_last"}, last_k, 42);
    check({name, "_count"}, got_n, 3);
    check({name, "_id0"}, ids[0], e0);
    check({name, "_id1"}, ids[1], e1);
    check({name, "_id2"}, ids[2], e2);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int sid;
    int slong;
    vec_t one;

    vecs[0] = '{btn: 2'd0, low: 40,  exp_evt: 1'b1, exp_long: 1'b0, exp_lat: 60};
    vecs[1] = '{btn: 2'd1, low: 15,  exp_evt: 1'b0, exp_long: 1'b0, exp_lat: 0};
    vecs[2] = '{btn: 2'd1, low: 16,  exp_evt: 1'b1, exp_long: 1'b0, exp_lat: 36};
    vecs[3] = '{btn: 2'd2, low: 300, exp_evt: 1'b1, exp_long: 1'b1, exp_lat: 120};
    vecs[4] = '{btn: 2'd2, low: 100, exp_evt: 1'b1, exp_long: 1'b0, exp_lat: 120};
    vecs[5] = '{btn: 2'd0, low: 101, exp_evt: 1'b1, exp_long: 1'b1, exp_lat: 120};

    rst_n = 1'b0;
    b_in = 3'b111;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_long", int'(evt_long), 0);
    check("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;

    // Table-driven single-button presses.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Bouncy press on btn0: five toggles, settle low 40 cycles, release.
    // The last low segment starts at edge 8, so evt_valid is seen at 68.
    do_reset();
    seen = 0;
    sid = -1;
    slong = -1;
    for (int k = 0; k <= 80; k++) begin
      if (k > 0) @(negedge clk);
      if (evt_valid && seen == 0) begin
        seen = k;
        sid = int'(evt_id);
        slong = int'(evt_long);
      end
      if (k <= 8 && (k % 2) == 0) b_in[0] = ~b_in[0];
      if (k == 48) b_in[0] = 1'b1;
    end
    check("bounce_lat", seen, 68);
    check("bounce_id", sid, 0);
    check("bounce_long", slong, 0);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("bounce_single", int'(evt_valid), 0);

    // Round-robin ordering.
    do_reset();
    sim_press(0, 1, 2, "rr_reset");
    sim_press(0, 1, 2, "rr_after2");
    one = '{btn: 2'd0, low: 20, exp_evt: 1'b1, exp_long: 1'b0, exp_lat: 40};
    run_vec(one, "rr_single0");
    sim_press(1, 2, 0, "rr_after0");

    // Back-pressure and overflow.
    do_reset();
    short_press(0);
    short_press(1);
    short_press(2);
    short_press(0);
    short_press(0);
    check("bp_ovf_pending", int'(overflow), 0);
    short_press(0);
    check("bp_ovf_set", int'(overflow), 1);
    check("bp_head_valid", int'(evt_valid), 1);
    check("bp_head0", int'(evt_id), 0);
    evt_ready = 1'b1;
    @(negedge clk);
    check("bp_head1", int'(evt_id), 1);
    @(negedge clk);
    check("bp_head2", int'(evt_id), 2);
    @(negedge clk);
    check("bp_head3", int'(evt_id), 0);
    @(negedge clk);
    check("bp_pend_valid", int'(evt_valid), 1);
    check("bp_pend_id", int'(evt_id), 0);
    check("bp_pend_long", int'(evt_long), 0);
    @(negedge clk);
    check("bp_drained", int'(evt_valid), 0);
    evt_ready = 1'b0;
    check("bp_ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("bp_ovf_clr", int'(overflow), 0);

    // Asynchronous reset mid-operation with btn1 held.
    do_reset();
    short_press(0);
    short_press(1);
    check("mid_queued", int'(evt_valid), 1);
    b_in[1] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_id", int'(evt_id), 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    seen = 0;
    sid = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (evt_valid && seen == 0) begin
        seen = k;
        sid = int'(evt_id);
      end
      if (k == 29) b_in[1] = 1'b1;
    end
    // The held button counts as a press from the reset release: the
    // release is driven at edge 30 of this reference, so evt_valid is at 50.
    check("mid_new_lat", seen, 49);
    check("mid_new_id", sid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
